// File: rtl/gray_conv_sched.sv
`default_nettype none
// ============================================================================
// Module      : gray_conv_sched
// Description : Round-robin shared Gray encoder / bit-serial Gray decoder with
//               an id-tagged valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_conv_sched #(
   parameter int W   = 8,
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_valid,
   input  logic [N-1:0]     req_mode,
   input  logic [N*W-1:0]   req_data,
   output logic [N-1:0]     req_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [IDW-1:0]   rsp_id,
   output logic [W-1:0]     rsp_data,
   output logic             busy
);

   localparam int KW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ENC  = 2'd1,
      S_DEC  = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_id;
   logic [W-1:0]    r_op;
   logic [W-1:0]    r_res;
   logic [KW-1:0]   r_k;
   logic            r_acc;

   logic            w_any;
   logic [IDW-1:0]  w_gnt;
   logic [IDW-1:0]  w_cand;
   logic [N-1:0]    w_gnt_oh;
   logic [W-1:0]    w_grant_data;
   logic            w_dec_bit;

   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
      wrap_inc = (int'(v) == N - 1) ? '0 : v + 1'b1;
   endfunction

   // Search upward from the round-robin pointer, wrapping modulo N.
   always_comb begin
      w_any  = 1'b0;
      w_gnt  = '0;
      w_cand = r_ptr;
      for (int j = 0; j < N; j++) begin
         if (!w_any && req_valid[w_cand]) begin
            w_any = 1'b1;
            w_gnt = w_cand;
         end
         w_cand = wrap_inc(w_cand);
      end
   end

   always_comb begin
      w_gnt_oh     = '0;
      w_grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (w_gnt == IDW'(i)) begin
            w_gnt_oh[i]  = 1'b1;
            w_grant_data = req_data[i*W +: W];
         end
      end
   end

   // Running prefix XOR: each new bit is the previous result bit XOR operand.
   assign w_dec_bit = r_acc ^ r_op[r_k];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_state_nxt = req_mode[w_gnt] ? S_DEC : S_ENC;
         S_ENC:   w_state_nxt = S_RESP;
         S_DEC:   if (r_k == '0) w_state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_id    <= '0;
         r_op    <= '0;
         r_res   <= '0;
         r_k     <= '0;
         r_acc   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_op  <= w_grant_data;
                  r_id  <= w_gnt;
                  r_ptr <= wrap_inc(w_gnt);
                  r_k   <= KW'(W - 1);
                  r_acc <= 1'b0;
                  r_res <= '0;
               end
            end
            S_ENC: r_res <= r_op ^ (r_op >> 1);
            S_DEC: begin
               r_res[r_k] <= w_dec_bit;
               r_acc      <= w_dec_bit;
               if (r_k != '0) r_k <= r_k - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Grant is blanked while reset is held so no request can be seen as taken.
   assign req_ready = (r_state == S_IDLE && w_any && !rst) ? w_gnt_oh : '0;
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_data  = rsp_valid ? r_res : '0;
   assign rsp_id    = rsp_valid ? r_id  : '0;
   assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_conv_sched
// Description : Directed self-checking bench for gray_conv_sched (W=8, N=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_conv_sched;

   localparam int W   = 8;
   localparam int N   = 4;
   localparam int IDW = 2;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_mode;
   logic [N*W-1:0]    req_data;
   logic [N-1:0]      req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_data;
   logic              busy;

   int checks = 0;
   int errors = 0;

   gray_conv_sched #(.W(W), .N(N), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_mode  (req_mode),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One request from requester g; lat is the accept-to-response cycle count.
   task automatic op(input string tag, input logic [3:0] mask, input int g,
                     input logic mode, input logic [7:0] din,
                     input logic [7:0] exp, input int lat);
      logic [3:0] oh;
      oh = 4'b0001 << g;
      req_mode = {4{mode}};
      req_data[g*8 +: 8] = din;
      req_valid = mask;
      #1;
      chk_eq({tag, "_grant"}, 32'(req_ready), 32'(oh));
      for (int i = 1; i <= lat; i++) begin
         step();
         if (i == 1) req_valid = 4'b0;
         if (i == lat - 1) chk_eq({tag, "_early"}, 32'(rsp_valid), 32'd0);
      end
      chk_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      chk_eq({tag, "_data"}, 32'(rsp_data), 32'(exp));
      chk_eq({tag, "_id"}, 32'(rsp_id), 32'(g));
      step();
      chk_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk_eq({tag, "_valid_after"}, 32'(rsp_valid), 32'd0);
   endtask

   logic [7:0] enc_tbl [4];
   logic [3:0] exp_oh;
   int         slot;

   initial begin
      enc_tbl = '{8'h01, 8'h03, 8'h02, 8'h06};
      rst = 1'b1;
      req_valid = 4'hF;
      req_mode = '0;
      req_data = '0;
      rsp_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst_ready", 32'(req_ready), 32'd0);
      chk_eq("rst_valid", 32'(rsp_valid), 32'd0);
      chk_eq("rst_busy", 32'(busy), 32'd0);
      chk_eq("rst_id", 32'(rsp_id), 32'd0);
      chk_eq("rst_data", 32'(rsp_data), 32'd0);
      req_valid = 4'h0;
      rst = 1'b0;
      step();
      chk_eq("post_rst_busy", 32'(busy), 32'd0);

      // Round-robin with all requesters valid in encode mode
      req_data = 32'h04030201;
      req_valid = 4'hF;
      for (int t = 0; t < 13; t++) begin
         #1;
         slot = (t / 3) % 4;
         exp_oh = 4'b0001 << slot;
         if (t % 3 == 0) chk_eq("rr_grant", 32'(req_ready), 32'(exp_oh));
         else chk_eq("rr_nogrant", 32'(req_ready), 32'd0);
         if (t % 3 == 2) begin
            chk_eq("rr_valid", 32'(rsp_valid), 32'd1);
            chk_eq("rr_data", 32'(rsp_data), 32'(enc_tbl[slot]));
            chk_eq("rr_id", 32'(rsp_id), 32'(slot));
         end
         if (t < 12) step();
      end
      req_valid = 4'h0;
      step();

      op("enc_b4", 4'b0001, 0, 1'b0, 8'hB4, 8'hEE, 2);
      op("dec_ee", 4'b0100, 2, 1'b1, 8'hEE, 8'hB4, 9);
      op("dec_80", 4'b1000, 3, 1'b1, 8'h80, 8'hFF, 9);
      op("wrap_dec_00", 4'b0011, 0, 1'b1, 8'h00, 8'h00, 9);

      // Backpressure with requesters 1 and 3 waiting
      req_mode = '0;
      req_data = {8'hF0, 8'h00, 8'h0F, 8'h55};
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      #1;
      chk_eq("bp_grant0", 32'(req_ready), 32'b0001);
      step();
      req_valid = 4'b0;
      step();
      req_valid = 4'b1010;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk_eq("bp_valid", 32'(rsp_valid), 32'd1);
         chk_eq("bp_data", 32'(rsp_data), 32'h7F);
         chk_eq("bp_id", 32'(rsp_id), 32'd0);
         chk_eq("bp_ready", 32'(req_ready), 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk_eq("bp_hold_valid", 32'(rsp_valid), 32'd1);
      step();
      chk_eq("bp_next_grant1", 32'(req_ready), 32'b0010);
      chk_eq("bp_valid_drop", 32'(rsp_valid), 32'd0);
      step();
      req_valid = 4'b1000;
      step();
      chk_eq("bp_r1_valid", 32'(rsp_valid), 32'd1);
      chk_eq("bp_r1_data", 32'(rsp_data), 32'h08);
      chk_eq("bp_r1_id", 32'(rsp_id), 32'd1);
      step();
      chk_eq("bp_next_grant3", 32'(req_ready), 32'b1000);
      step();
      req_valid = 4'b0;
      step();
      chk_eq("bp_r3_data", 32'(rsp_data), 32'h88);
      chk_eq("bp_r3_id", 32'(rsp_id), 32'd3);
      step();

      // Reset during the 4th decode cycle of requester 1
      req_mode = 4'hF;
      req_data[15:8] = 8'hA5;
      req_valid = 4'b0010;
      #1;
      chk_eq("mrst_grant1", 32'(req_ready), 32'b0010);
      step();
      req_valid = 4'b0;
      step();
      step();
      step();
      chk_eq("mrst_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk_eq("mrst_busy", 32'(busy), 32'd0);
      chk_eq("mrst_valid", 32'(rsp_valid), 32'd0);
      step();
      step();
      rst = 1'b0;
      req_mode = '0;
      req_data[7:0] = 8'h01;
      req_valid = 4'b1001;
      #1;
      chk_eq("mrst_ptr0_grant", 32'(req_ready), 32'b0001);
      step();
      req_valid = 4'b0;
      chk_eq("mrst_no_rsp", 32'(rsp_valid), 32'd0);
      step();
      chk_eq("mrst_r0_valid", 32'(rsp_valid), 32'd1);
      chk_eq("mrst_r0_data", 32'(rsp_data), 32'h01);
      chk_eq("mrst_r0_id", 32'(rsp_id), 32'd0);
      step();
      chk_eq("mrst_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gray_conv_sched.md
Name: gray_conv_sched

Overview:
- Shared-resource scheduler for an adjacent-bit XOR converter datapath (Gray code). Encode: `g = b ^ (b >> 1)`; decode is the inverse prefix XOR.
- N requesters share one converter instance. A round-robin arbiter grants one request at a time.
- Encode completes in a single datapath cycle. Decode is sequenced bit-serially, MSB to LSB, over W cycles.
- Result is returned on a valid/ready response channel tagged with the requester id. Sits between the control-plane clients and the converter datapath.

Parameters:
- W, 8, data width in bits (W >= 2).
- N, 4, number of requesters (N >= 2).
- IDW, clog2(N), width of the response id.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N  per-requester request valid.
- req_mode  input  N  per-requester mode: 0 = encode, 1 = decode.
- req_data  input  N*W  per-requester operand; requester i occupies bits [i*W +: W].
- req_ready  output  N  one-hot grant/accept; a request is taken when `req_valid[i] & req_ready[i]`.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_data  output  W  converted value.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous. While `rst` = 1 and after release:
  - state = IDLE; rr_ptr = 0; bit counter = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `busy` = 0, `req_ready` = 0.
- States: IDLE, ENC, DEC, RESP.
- IDLE:
  - If any `req_valid` bit is set, grant index g = first set bit searching upward from rr_ptr, wrapping modulo N.
  - `req_ready[g]` = 1 combinationally in that cycle only; all other `req_ready` bits stay 0.
  - On the clock edge, capture `op = req_data[g]`, `mode = req_mode[g]`, `id = g`, and set rr_ptr = (g+1) mod N.
  - Next state is ENC when mode = 0, DEC when mode = 1.
  - If no `req_valid` bit is set, stay in IDLE with `req_ready` = 0.
- ENC:
  - One cycle. `res = op ^ (op >> 1)` with a zero shifted into the MSB.
  - Next state is RESP.
- DEC:
  - Counter k starts at W-1 and decrements once per cycle.
  - `res[W-1] = op[W-1]`; for k < W-1, `res[k] = res[k+1] ^ op[k]`.
  - After the cycle with k = 0, next state is RESP. DEC therefore occupies exactly W cycles.
- RESP:
  - `rsp_valid` = 1, with `rsp_data` = res and `rsp_id` = id.
  - All three signals are held stable until `rsp_ready` = 1.
  - On the accept edge, go to IDLE. There is no grant in the RESP cycle; the next grant can occur at the earliest in the following IDLE cycle.
- `req_ready` is 0 in every state other than IDLE. Requests arriving while busy wait with `req_valid` held; they are not dropped.
- Latency, measured from accept cycle C (the cycle in which `req_valid & req_ready` is true):
  - Encode: `rsp_valid` first high in cycle C+2.
  - Decode: `rsp_valid` first high in cycle C+W+1.
- Throughput with `rsp_ready` tied high:
  - Encode: one result every 3 cycles.
  - Decode: one result every W+2 cycles.
- Arbitration fairness: with all N requesters continuously valid, grants rotate 0,1,…,N-1,0. No requester waits more than N-1 grants.
- Reset mid-operation (any state): the operation is aborted. No response is produced. State and outputs return to their reset values immediately (asynchronously). rr_ptr returns to 0.
- `req_valid[i]` dropping before being granted is legal; that requester is simply skipped.
- Data arithmetic is pure bitwise XOR. There is no carry, and widths are W throughout.

Test Plan:
- Requester 0 sends encode, `req_data` = 0xB4, accepted in cycle C; `rsp_ready` = 1.
  → `rsp_valid` = 1 in cycle C+2 with `rsp_data` = 0xEE and `rsp_id` = 0; `busy` falls the next cycle.
- Requester 2 sends decode, `req_data` = 0xEE, with W = 8.
  → `rsp_valid` first high in cycle C+9 with `rsp_data` = 0xB4 and `rsp_id` = 2.
  → Also check decode of 0x80 gives 0xFF and decode of 0x00 gives 0x00.
- All 4 requesters hold `req_valid` = 1 in encode mode, operands 0x01/0x02/0x03/0x04; `rsp_ready` = 1.
  → Grant order is 0,1,2,3,0.
  → Responses are 0x01, 0x03, 0x02, 0x06 with ids 0, 1, 2, 3.
  → Grants are spaced 3 cycles apart.
- Backpressure: while a response is pending, `rsp_ready` is held 0 for 5 cycles with requesters 1 and 3 valid.
  → `rsp_valid`, `rsp_data` and `rsp_id` stay stable for all 5 cycles, and `req_ready` = 0.
  → After the accept edge, requester 1 is granted next.
- Reset pulse in the 4th DEC cycle of a decode from requester 1.
  → `rsp_valid` stays 0, `busy` = 0 immediately.
  → After release, with requesters 0 and 3 both valid, requester 0 is granted first (rr_ptr = 0).
- Requester 3 is granted with rr_ptr = 3.
  → rr_ptr wraps to 0, so the next grant with requesters 0 and 1 both valid goes to 0.
